ps2_poly_voicer: RTL and testbench
==================================

Name: ps2_poly_voicer

Overview:
- Parametrised successor to the single-tone keyboard-audio path: turns PS/2 keyboard scancodes into polyphonic square-wave audio.
- Decodes make, break (F0) and extended (E0) sequences, assigns held keys to NUM_VOICES oscillators, and mixes the active voices into one signed sample.
- Sits between the PS/2 receiver's byte output and the audio codec's sample-write interface.

Parameters:
NUM_VOICES, 4, number of simultaneous oscillators (1..8)
SAMPLE_W, 24, width of signed output sample
AMP, 24'h100000, per-voice amplitude, positive, < 2^(SAMPLE_W-1)
DIV_BASE, 20000, half-period in clocks for scancode 0x00
DIV_STEP, 64, extra half-period clocks per scancode unit
STEAL, 1, 1 = steal the oldest voice when all voices are busy; 0 = drop the new note and flag overflow

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
scan_code  in  8  byte from the PS/2 receiver
scan_valid  in  1  one-cycle strobe, scan_code valid
audio_ready  in  1  one-cycle strobe, codec accepts a new sample
sample_out  out  SAMPLE_W  signed mixed sample
sample_valid  out  1  one-cycle strobe, sample_out updated
voice_active  out  NUM_VOICES  voice i holds a key
last_code  out  8  last make code accepted (drives LEDR/HEX)
overflow  out  1  sticky; set on a dropped note (STEAL=0)

Behaviour:
- Reset, async on resetn low: all outputs 0, every voice free, FSM in IDLE, steal pointer 0, all phase bits and counters 0.
- Decode FSM, advances only on scan_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; 00 or FA -> IDLE, ignored; otherwise MAKE(code), stay IDLE.
  - BRK: any byte -> BREAK(code), go to IDLE.
  - EXT: F0 -> EXTBRK; otherwise ignore, go to IDLE.
  - EXTBRK: any byte -> ignore, go to IDLE.
  - Extended keys never sound.
- MAKE(c):
  - If a voice already holds c (typematic repeat): no change.
  - Otherwise allocate the lowest-index free voice.
  - If no voice is free and STEAL=1: replace the voice at the steal pointer, then advance the pointer modulo NUM_VOICES.
  - If no voice is free and STEAL=0: discard the note and set overflow.
  - last_code <= c whenever the key is accepted or stolen.
- BREAK(c): free every voice holding c. If none holds c: no-op.
- Latency: scan_valid in cycle N -> voice_active and last_code updated in cycle N+1.
- Oscillators: per voice, half-period H = DIV_BASE + code*DIV_STEP.
  - Computed in 32 bits; parameters are chosen so no overflow.
  - Counter runs 0..H-1. On reaching H-1: counter <= 0 and phase toggles.
  - Free voices hold counter = 0 and phase = 0.
  - On allocation or steal the counter and phase restart at 0 in the same update cycle.
- Mix: on audio_ready, sum over active voices of (phase ? +AMP : -AMP).
  - Saturate to [-(2^(SAMPLE_W-1)), 2^(SAMPLE_W-1)-1].
  - Register into sample_out with sample_valid high for exactly one cycle, at N+1 after audio_ready at N.
  - sample_out holds its value between strobes. No active voices -> 0.
- Simultaneous scan_valid and audio_ready: the mix uses the voice state from before the scancode update.
- A MAKE and a BREAK can never land in the same cycle (one byte per strobe).
- overflow clears only on reset.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE, and the next byte is decoded as a make.

Test Plan:
- Reset, then press 1C (A): voice_active=0001 and last_code=1C one cycle after the strobe. The voice 0 phase toggles every 20000+28*64=21792 clocks.
- Bytes 1C, F0, 1C: voice_active 0001 -> 0000. Repeat 1C,1C,1C while held -> voice_active stays 0001, one voice only.
- STEAL=1, NUM_VOICES=4, makes 1C,1B,23,2B,34 -> voice 0 becomes 34, last_code=34, pointer=1. Then make 33 -> voice 1 becomes 33.
- STEAL=0, same five makes -> 34 dropped, overflow=1, last_code=2B, voice_active=1111.
- Two voices with equal phase, AMP=0x100000, audio_ready pulse -> sample_out=+/-0x200000 next cycle with sample_valid one cycle. With SAMPLE_W=22 the same case saturates to 0x1FFFFF.
- Sequences E0 75 and E0 F0 75 -> no voice change. F0 then resetn low, then 1C -> voice 0 active.

Source files
------------

// File: rtl/ps2_poly_voicer.sv
// PS/2 scancode to polyphonic square-wave voicer: decodes make/break/extended
// byte sequences, maps held keys onto oscillators and mixes them into one sample.
module ps2_poly_voicer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int AMP        = 32'h0010_0000,
  parameter int DIV_BASE   = 20000,
  parameter int DIV_STEP   = 64,
  parameter int STEAL      = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [7:0]            scan_code,
  input  logic                  scan_valid,
  input  logic                  audio_ready,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [7:0]            last_code,
  output logic                  overflow,
  output logic [1:0]            o_dbg_state
);

  // Handshakes: scan_valid and audio_ready are single-cycle strobes with no
  // back-pressure (every strobe is consumed on the edge it is sampled);
  // sample_valid is a one-cycle strobe marking a fresh sample_out.

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W = SAMPLE_W + 4;
  localparam logic signed [SUM_W-1:0] AMP_S = SUM_W'(AMP);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BRK    = 2'd1,
    S_EXT    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_make;
  logic   w_break;

  logic [NUM_VOICES-1:0] w_busy;
  logic [NUM_VOICES-1:0] w_phase;
  logic [NUM_VOICES-1:0] w_hit;
  logic [VW-1:0]         w_free_idx;
  logic                  w_any_free;
  logic [VW-1:0]         w_alloc_idx;
  logic                  w_new_key;
  logic                  w_alloc_en;
  logic                  w_steal;
  logic                  w_drop;
  logic [VW-1:0]         r_steal_ptr;

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_sat;
  logic [SAMPLE_W-1:0]     r_sample;
  logic                    r_sample_valid;
  logic [7:0]              r_last_code;
  logic                    r_overflow;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_code == 8'hF0)      w_state_nxt = S_BRK;
          else if (scan_code == 8'hE0) w_state_nxt = S_EXT;
          else if (scan_code != 8'h00 && scan_code != 8'hFA) w_make = 1'b1;
        end
        S_BRK: begin
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT:    w_state_nxt = (scan_code == 8'hF0) ? S_EXTBRK : S_IDLE;
        S_EXTBRK: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Downward scan so the lowest-index free voice wins.
  always_comb begin
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_free_idx = i[VW-1:0];
        w_any_free = 1'b1;
      end
    end
  end

  assign w_new_key   = w_make && !(|w_hit);
  assign w_steal     = w_new_key && !w_any_free && (STEAL != 0);
  assign w_drop      = w_new_key && !w_any_free && (STEAL == 0);
  assign w_alloc_en  = w_new_key && (w_any_free || (STEAL != 0));
  assign w_alloc_idx = w_any_free ? w_free_idx : r_steal_ptr;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_steal_ptr <= '0;
      r_last_code <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (w_steal) begin
        r_steal_ptr <= (r_steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
      end
      if (w_alloc_en) r_last_code <= scan_code;
      if (w_drop)     r_overflow  <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic        r_busy;
    logic [7:0]  r_code;
    logic [31:0] r_cnt;
    logic        r_phase;
    logic [31:0] w_half;
    logic        w_alloc;

    assign w_half     = 32'(DIV_BASE) + 32'(r_code) * 32'(DIV_STEP);
    assign w_alloc    = w_alloc_en && (w_alloc_idx == VW'(g));
    assign w_busy[g]  = r_busy;
    assign w_phase[g] = r_phase;
    assign w_hit[g]   = r_busy && (r_code == scan_code);

    // A stolen voice restarts from phase 0 just like a fresh allocation.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_busy  <= 1'b0;
        r_code  <= 8'h00;
        r_cnt   <= 32'd0;
        r_phase <= 1'b0;
      end else if (w_alloc) begin
        r_busy  <= 1'b1;
        r_code  <= scan_code;
        r_cnt   <= 32'd0;
        r_phase <= 1'b0;
      end else if (w_break && w_hit[g]) begin
        r_busy  <= 1'b0;
        r_cnt   <= 32'd0;
        r_phase <= 1'b0;
      end else if (r_busy) begin
        if (r_cnt == w_half - 32'd1) begin
          r_cnt   <= 32'd0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  // Mix reads the registered voice state, i.e. the state before any
  // scancode landing on the same edge.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_busy[i]) w_sum = w_phase[i] ? (w_sum + AMP_S) : (w_sum - AMP_S);
    end
    if (w_sum > MAX_S)      w_sat = MAX_S;
    else if (w_sum < MIN_S) w_sat = MIN_S;
    else                    w_sat = w_sum;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= audio_ready;
      if (audio_ready) r_sample <= w_sat[SAMPLE_W-1:0];
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_sample_valid;
  assign voice_active = w_busy;
  assign last_code    = r_last_code;
  assign overflow     = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_poly_voicer.sv
// Bench for ps2_poly_voicer: four instances share one stimulus stream
// (steal, no-steal, narrow saturating sample, fast oscillators for random runs).
module tb_ps2_poly_voicer;

  localparam int AMP_V  = 32'h0010_0000;
  localparam int R_BASE = 3;
  localparam int R_STEP = 1;
  localparam int S_MAX  = (1 << 23) - 1;
  localparam int S_MIN  = -(1 << 23);

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       audio_ready = 1'b0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] a_sample, b_sample, r_sample;
  logic [21:0] c_sample;
  logic        a_sv, b_sv, c_sv, r_sv;
  logic [3:0]  a_act, b_act, c_act, r_act;
  logic [7:0]  a_last, b_last, c_last, r_last;
  logic        a_ovf, b_ovf, c_ovf, r_ovf;
  logic [1:0]  a_dbg, b_dbg, c_dbg, r_dbg;

  ps2_poly_voicer u_a (
    .CLOCK_50(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .audio_ready(audio_ready), .sample_out(a_sample), .sample_valid(a_sv),
    .voice_active(a_act), .last_code(a_last), .overflow(a_ovf), .o_dbg_state(a_dbg));

  ps2_poly_voicer #(.STEAL(0)) u_b (
    .CLOCK_50(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .audio_ready(audio_ready), .sample_out(b_sample), .sample_valid(b_sv),
    .voice_active(b_act), .last_code(b_last), .overflow(b_ovf), .o_dbg_state(b_dbg));

  ps2_poly_voicer #(.SAMPLE_W(22), .DIV_BASE(20), .DIV_STEP(0)) u_c (
    .CLOCK_50(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .audio_ready(audio_ready), .sample_out(c_sample), .sample_valid(c_sv),
    .voice_active(c_act), .last_code(c_last), .overflow(c_ovf), .o_dbg_state(c_dbg));

  ps2_poly_voicer #(.DIV_BASE(R_BASE), .DIV_STEP(R_STEP)) u_r (
    .CLOCK_50(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .audio_ready(audio_ready), .sample_out(r_sample), .sample_valid(r_sv),
    .voice_active(r_act), .last_code(r_last), .overflow(r_ovf), .o_dbg_state(r_dbg));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] code;
    logic [3:0] act_a;
    logic [7:0] last_a;
    logic [3:0] act_b;
    logic [7:0] last_b;
    bit         ovf_b;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input logic [7:0] code, input logic [3:0] act_a,
                     input logic [7:0] last_a, input logic [3:0] act_b,
                     input logic [7:0] last_b, input bit ovf_b);
    vec_t v;
    v.rst = rst; v.code = code; v.act_a = act_a; v.last_a = last_a;
    v.act_b = act_b; v.last_b = last_b; v.ovf_b = ovf_b;
    vecs.push_back(v);
  endtask

  // Reference model: held keys as a list of (code, allocation edge) slots.
  bit         m_busy[4];
  logic [7:0] m_code[4];
  int         m_alloc[4];
  int         m_ptr;
  logic [7:0] m_last;
  int         m_pre;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0; m_code[i] = 8'h00; m_alloc[i] = 0;
    end
    m_ptr = 0; m_last = 8'h00; m_pre = 0;
  endtask

  task automatic model_make(input logic [7:0] b, input int e);
    for (int i = 0; i < 4; i++) if (m_busy[i] && m_code[i] == b) return;
    for (int i = 0; i < 4; i++) begin
      if (!m_busy[i]) begin
        m_busy[i] = 1'b1; m_code[i] = b; m_alloc[i] = e; m_last = b;
        return;
      end
    end
    m_code[m_ptr] = b; m_alloc[m_ptr] = e; m_last = b;
    m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic model_byte(input logic [7:0] b, input int e);
    if (m_pre == 1) begin
      for (int i = 0; i < 4; i++) if (m_busy[i] && m_code[i] == b) m_busy[i] = 1'b0;
      m_pre = 0;
    end else if (m_pre == 2) begin
      m_pre = (b == 8'hF0) ? 3 : 0;
    end else if (m_pre == 3) begin
      m_pre = 0;
    end else if (b == 8'hF0) begin
      m_pre = 1;
    end else if (b == 8'hE0) begin
      m_pre = 2;
    end else if (b != 8'h00 && b != 8'hFA) begin
      model_make(b, e);
    end
  endtask

  // Mix strobe sampled on edge e sees each voice after (e-1-alloc) edges.
  function automatic int model_mix(input int e);
    int s;
    int k;
    int h;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_busy[i]) begin
        k = e - 1 - m_alloc[i];
        h = R_BASE + int'(m_code[i]) * R_STEP;
        s += (((k / h) % 2) == 1) ? AMP_V : -AMP_V;
      end
    end
    if (s > S_MAX) s = S_MAX;
    if (s < S_MIN) s = S_MIN;
    return s;
  endfunction

  logic [7:0] pool[13] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h35,
                           8'hF0, 8'hF0, 8'hE0, 8'h00, 8'hFA, 8'h75};

  initial begin
    int a;
    int e;
    int exp_s;
    bit ar;
    logic [3:0] exp_act;

    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;

    //        rst code   act_a last_a act_b last_b ovf_b
    add(1, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 0);
    add(0, 8'h1C, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'hF0, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'h1C, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'h1C, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'h1C, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'h1C, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'hF0, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'h1C, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'hE0, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'h75, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'hE0, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'hF0, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'h75, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'h00, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'hFA, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(0, 8'hF0, 4'h0, 8'h1C, 4'h0, 8'h1C, 0);
    add(1, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 0);
    add(0, 8'h1C, 4'h1, 8'h1C, 4'h1, 8'h1C, 0);
    add(0, 8'h1B, 4'h3, 8'h1B, 4'h3, 8'h1B, 0);
    add(0, 8'h23, 4'h7, 8'h23, 4'h7, 8'h23, 0);
    add(0, 8'h2B, 4'hF, 8'h2B, 4'hF, 8'h2B, 0);
    add(0, 8'h34, 4'hF, 8'h34, 4'hF, 8'h2B, 1);
    add(0, 8'h33, 4'hF, 8'h33, 4'hF, 8'h2B, 1);
    add(0, 8'hF0, 4'hF, 8'h33, 4'hF, 8'h2B, 1);
    add(0, 8'h1C, 4'hF, 8'h33, 4'hE, 8'h2B, 1);
    add(0, 8'hF0, 4'hF, 8'h33, 4'hE, 8'h2B, 1);
    add(0, 8'h34, 4'hE, 8'h33, 4'hE, 8'h2B, 1);
    add(0, 8'hF0, 4'hE, 8'h33, 4'hE, 8'h2B, 1);
    add(0, 8'h33, 4'hC, 8'h33, 4'hE, 8'h2B, 1);
    add(0, 8'h1C, 4'hD, 8'h1C, 4'hF, 8'h1C, 1);
    add(0, 8'h34, 4'hF, 8'h34, 4'hF, 8'h1C, 1);
    add(0, 8'h35, 4'hF, 8'h35, 4'hF, 8'h1C, 1);
    add(0, 8'hF0, 4'hF, 8'h35, 4'hF, 8'h1C, 1);
    add(0, 8'h23, 4'hF, 8'h35, 4'hB, 8'h1C, 1);
    add(0, 8'hF0, 4'hF, 8'h35, 4'hB, 8'h1C, 1);
    add(0, 8'h35, 4'hB, 8'h35, 4'hB, 8'h1C, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        resetn = 1'b0;
        scan_valid = 1'b0;
      end else begin
        scan_valid = 1'b1;
        scan_code = vecs[i].code;
      end
      step();
      resetn = 1'b1;
      scan_valid = 1'b0;
      chk($sformatf("act_a[%0d]", i), 32'(a_act), 32'(vecs[i].act_a));
      chk($sformatf("last_a[%0d]", i), 32'(a_last), 32'(vecs[i].last_a));
      chk($sformatf("ovf_a[%0d]", i), 32'(a_ovf), 32'd0);
      chk($sformatf("act_b[%0d]", i), 32'(b_act), 32'(vecs[i].act_b));
      chk($sformatf("last_b[%0d]", i), 32'(b_last), 32'(vecs[i].last_b));
      chk($sformatf("ovf_b[%0d]", i), 32'(b_ovf), 32'(vecs[i].ovf_b));
      if (vecs[i].rst) begin
        chk("rst_samples", 32'({a_sample, b_sample, c_sample, r_sample} != '0), 32'd0);
        chk("rst_valids", 32'({a_sv, b_sv, c_sv, r_sv}), 32'd0);
        chk("rst_dbg", 32'({a_dbg, b_dbg, c_dbg, r_dbg}), 32'd0);
        chk("rst_c_r", 32'({c_act, r_act, c_last, r_last, c_ovf, r_ovf}), 32'd0);
      end
    end

    // Single voice on key 1C: half period 21792 clocks.
    resetn = 1'b0; step(); resetn = 1'b1;
    a = cyc + 1;
    scan_code = 8'h1C; scan_valid = 1'b1;
    step();
    scan_valid = 1'b0;
    while (cyc + 1 < a + 21792) step();
    audio_ready = 1'b1;
    step();
    chk("phase_lo_valid", 32'(a_sv), 32'd1);
    chk("phase_lo_sample", 32'(a_sample), 32'h00F0_0000);
    step();
    audio_ready = 1'b0;
    chk("phase_hi_sample", 32'(a_sample), 32'h0010_0000);
    step();
    chk("hold_valid", 32'(a_sv), 32'd0);
    chk("hold_sample", 32'(a_sample), 32'h0010_0000);

    // Two voices in step: -2*AMP, then +2*AMP saturating in the 22-bit instance.
    resetn = 1'b0; step(); resetn = 1'b1;
    a = cyc + 1;
    scan_code = 8'h1C; scan_valid = 1'b1;
    step();
    scan_code = 8'h1B;
    step();
    scan_valid = 1'b0;
    audio_ready = 1'b1;
    step();
    audio_ready = 1'b0;
    chk("two_neg_a", 32'(a_sample), 32'h00E0_0000);
    chk("two_neg_c", 32'(c_sample), 32'h0020_0000);
    chk("two_valid_c", 32'(c_sv), 32'd1);
    chk("two_act_c", 32'(c_act), 32'h3);
    step();
    chk("two_strobe_once", 32'({a_sv, c_sv}), 32'd0);
    while (cyc + 1 < a + 31) step();
    audio_ready = 1'b1;
    step();
    audio_ready = 1'b0;
    chk("sat_pos_c", 32'(c_sample), 32'h001F_FFFF);
    chk("sat_a_still_low", 32'(a_sample), 32'h00E0_0000);

    // Random byte stream against the model, fast-oscillator instance.
    resetn = 1'b0; step(); resetn = 1'b1;
    model_reset();
    exp_s = 0;
    for (int n = 0; n < 3000; n++) begin
      scan_valid  = ($urandom_range(0, 3) == 0);
      scan_code   = pool[$urandom_range(0, 12)];
      audio_ready = ($urandom_range(0, 2) == 0);
      ar = audio_ready;
      e = cyc + 1;
      if (audio_ready) exp_s = model_mix(e);
      if (scan_valid) model_byte(scan_code, e);
      step();
      for (int i = 0; i < 4; i++) exp_act[i] = m_busy[i];
      chk("rnd_act", 32'(r_act), 32'(exp_act));
      chk("rnd_last", 32'(r_last), 32'(m_last));
      chk("rnd_valid", 32'(r_sv), 32'(ar));
      chk("rnd_sample", 32'(r_sample), exp_s & 32'h00FF_FFFF);
      chk("rnd_ovf", 32'(r_ovf), 32'd0);
    end
    scan_valid = 1'b0;
    audio_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
